// File: rtl/prng_pool.sv
// prng_pool: NUM_LANES xorshift64 lanes fill an OUTLENGTH-bit random word behind a valid/ready port.
// Define PRNG_HEALTH_EN to add the sticky health_err monitor (stuck lane / repeated chunk).
module prng_pool #(
  parameter int          OUTLENGTH = 1600,
  parameter int          NUM_LANES = 4,
  parameter logic [63:0] SEED_BASE = 64'h9E3779B97F4A7C15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ren,
  output logic                 dout_valid,
  output logic [OUTLENGTH-1:0] dout,
  input  logic                 seed_we,
  input  logic [7:0]           seed_lane,
  input  logic [63:0]          seed_data
`ifdef PRNG_HEALTH_EN
  ,
  output logic                 health_err
`endif
);

  localparam int CHUNK       = 64 * NUM_LANES;
  localparam int FILL_CYCLES = (OUTLENGTH + CHUNK - 1) / CHUNK;
  localparam int BUFW        = FILL_CYCLES * CHUNK;
  localparam int CW          = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;

  typedef enum logic {S_FILL, S_READY} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    fill_cnt_reg, fill_cnt_next;
  logic [BUFW-1:0]  buf_reg, buf_next;
  logic [CHUNK-1:0] chunk_next;
  logic [63:0]      seed_val;
  logic             seed_hit, handshake, step_en, health_ok;

`ifdef PRNG_HEALTH_EN
  logic [NUM_LANES-1:0] lane_stuck;
  logic                 health_err_reg;
  assign health_ok  = !health_err_reg;
  assign health_err = health_err_reg;
`else
  assign health_ok  = 1'b1;
`endif

  // Out-of-range lane indices are treated as if no write happened at all.
  assign seed_hit   = seed_we && ({1'b0, seed_lane} < 9'(NUM_LANES));
  assign seed_val   = (seed_data == 64'd0) ? SEED_BASE : seed_data;
  assign dout_valid = (state_reg == S_READY) && health_ok;
  assign dout       = dout_valid ? buf_reg[OUTLENGTH-1:0] : '0;
  assign handshake  = ren && dout_valid;
  assign step_en    = (state_reg == S_FILL) && !seed_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [63:0] lane_reg, step_a, step_b, step_next;

      assign step_a    = lane_reg ^ (lane_reg << 13);
      assign step_b    = step_a ^ (step_a >> 7);
      assign step_next = step_b ^ (step_b << 17);
      assign chunk_next[gi*64 +: 64] = step_next;
`ifdef PRNG_HEALTH_EN
      assign lane_stuck[gi] = (step_next == lane_reg);
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lane_reg <= SEED_BASE ^ 64'(gi + 1);
        end else if (seed_hit) begin
          if (seed_lane == 8'(gi)) lane_reg <= seed_val;
        end else if (step_en) begin
          lane_reg <= step_next;
        end
      end
    end

    // Newest chunk enters at the LSB end; the oldest falls off the top.
    if (BUFW > CHUNK) begin : g_shift
      assign buf_next = {buf_reg[BUFW-CHUNK-1:0], chunk_next};
    end else begin : g_noshift
      assign buf_next = chunk_next;
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    if (seed_hit || handshake) begin
      state_next    = S_FILL;
      fill_cnt_next = '0;
    end else if (state_reg == S_FILL) begin
      if (fill_cnt_reg == CW'(FILL_CYCLES - 1)) begin
        state_next = S_READY;
      end else begin
        fill_cnt_next = fill_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_FILL;
      fill_cnt_reg <= '0;
      buf_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      fill_cnt_reg <= fill_cnt_next;
      if (step_en) buf_reg <= buf_next;
    end
  end

`ifdef PRNG_HEALTH_EN
  // Buffer LSB chunk is always the previous lane output, so it doubles as the repeat reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      health_err_reg <= 1'b0;
    end else if (step_en && ((|lane_stuck) || (chunk_next == buf_reg[CHUNK-1:0]))) begin
      health_err_reg <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_prng_pool.sv
// Scoreboard bench for prng_pool: a word-level reference model queues expected words;
// a negedge monitor checks valid timing, word contents, zeroing, stability and uniqueness.
`timescale 1ns/1ps
module tb_prng_pool;
  localparam int          OUTLENGTH = 1600;
  localparam int          NL        = 4;
  localparam int          CHUNK     = 64 * NL;
  localparam int          FC        = (OUTLENGTH + CHUNK - 1) / CHUNK;
  localparam logic [63:0] SEED_BASE = 64'h9E3779B97F4A7C15;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 ren = 1'b0;
  logic                 seed_we = 1'b0;
  logic [7:0]           seed_lane = 8'd0;
  logic [63:0]          seed_data = 64'd0;
  logic                 dout_valid;
  logic [OUTLENGTH-1:0] dout;
`ifdef PRNG_HEALTH_EN
  logic                 health_err;
`endif

  prng_pool #(.OUTLENGTH(OUTLENGTH), .NUM_LANES(NL), .SEED_BASE(SEED_BASE)) dut (
    .clk(clk), .rst(rst), .ren(ren), .dout_valid(dout_valid), .dout(dout),
    .seed_we(seed_we), .seed_lane(seed_lane), .seed_data(seed_data)
`ifdef PRNG_HEALTH_EN
    , .health_err(health_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [OUTLENGTH-1:0] word; int due; } exp_t;
  exp_t                 exp_q[$];
  logic [OUTLENGTH-1:0] seen_q[$];
  logic [63:0]          m_lane[NL];
  logic [CHUNK-1:0]     m_ch[FC];
  int                   m_nch;
  bit                   m_ready;
  int                   cyc = 0, n_cmp = 0, n_bad = 0;
  bit                   mon_en = 0, prev_valid = 0;
  logic [OUTLENGTH-1:0] last_word;

  function automatic logic [63:0] xs(input logic [63:0] x);
    x ^= x << 13;
    x ^= x >> 7;
    x ^= x << 17;
    return x;
  endfunction

  task automatic check(input string name, input bit ok, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, got, want);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NL; i++) m_lane[i] = SEED_BASE ^ 64'(i + 1);
    m_nch   = 0;
    m_ready = 0;
    exp_q.delete();
    seen_q.delete();
  endtask

  // Reference behaviour for one clock edge with the given inputs.
  task automatic model_edge(input bit r, input bit w, input logic [7:0] l, input logic [63:0] d);
    logic [CHUNK-1:0]    c;
    logic [FC*CHUNK-1:0] full;
    exp_t                e;
    cyc++;
    if (w && l < NL) begin
      m_lane[l] = (d == 64'd0) ? SEED_BASE : d;
      m_nch = 0;
      m_ready = 0;
    end else if (r && m_ready) begin
      m_nch = 0;
      m_ready = 0;
    end else if (!m_ready) begin
      for (int i = 0; i < NL; i++) begin
        m_lane[i] = xs(m_lane[i]);
        c[i*64 +: 64] = m_lane[i];
      end
      m_ch[m_nch] = c;
      m_nch++;
      if (m_nch == FC) begin
        for (int k = 0; k < FC; k++) full[(FC-1-k)*CHUNK +: CHUNK] = m_ch[k];
        e.word = full[OUTLENGTH-1:0];
        e.due  = cyc;
        exp_q.push_back(e);
        m_ready = 1;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit w, input logic [7:0] l, input logic [63:0] d);
    ren = r; seed_we = w; seed_lane = l; seed_data = d;
    @(posedge clk);
    model_edge(r, w, l, d);
    @(negedge clk);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 2 * FC && !m_ready; i++) cycle(0, 0, 8'd0, 64'd0);
  endtask

  // Monitor: decoupled from stimulus, pops expectations whenever a fresh word appears.
  always @(negedge clk) begin
    exp_t e;
    bit   dup;
    if (mon_en && !rst) begin
      check("valid", dout_valid === m_ready, 128'(dout_valid), 128'(m_ready));
      if (dout_valid === 1'b1) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 1'b0, dout[127:0], 128'd0);
          end else begin
            e = exp_q.pop_front();
            check("word", dout === e.word, dout[127:0], e.word[127:0]);
            check("latency", cyc == e.due, 128'(cyc), 128'(e.due));
            dup = 0;
            foreach (seen_q[i]) if (seen_q[i] === dout) dup = 1;
            check("unique", !dup, 128'(dup), 128'd0);
            seen_q.push_back(dout);
          end
          last_word = dout;
        end else begin
          check("stable", dout === last_word, dout[127:0], last_word[127:0]);
        end
      end else begin
        check("dout_zero", dout === '0, dout[127:0], 128'd0);
      end
      prev_valid = dout_valid;
    end
  end

  initial begin
    bit          r, w;
    logic [7:0]  l;
    logic [63:0] d;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", dout_valid === 1'b0, 128'(dout_valid), 128'd0);
    check("rst_dout", dout === '0, dout[127:0], 128'd0);
    rst = 0; prev_valid = 0; mon_en = 1;

    // Reset fill, then word held while ren=0
    repeat (FC + 5) cycle(0, 0, 8'd0, 64'd0);

    // Single-cycle handshakes
    repeat (3) begin
      wait_ready();
      cycle(1, 0, 8'd0, 64'd0);
      repeat (FC + 2) cycle(0, 0, 8'd0, 64'd0);
    end

    // Continuous ren: 100 words
    repeat (100 * (FC + 1)) cycle(1, 0, 8'd0, 64'd0);
    cycle(0, 0, 8'd0, 64'd0);

    // Reseed lane 2 with 1 on fill cycle 3
    wait_ready();
    cycle(1, 0, 8'd0, 64'd0);
    repeat (2) cycle(0, 0, 8'd0, 64'd0);
    cycle(0, 1, 8'd2, 64'd1);
    repeat (FC + 2) cycle(0, 0, 8'd0, 64'd0);

    // Zero seed, illegal lane while ready, seed+handshake on the same edge
    wait_ready();
    cycle(1, 0, 8'd0, 64'd0);
    cycle(0, 1, 8'd1, 64'd0);
    wait_ready();
    cycle(0, 1, 8'd9, 64'h0123_4567_89AB_CDEF);
    repeat (3) cycle(0, 0, 8'd0, 64'd0);
    cycle(1, 1, 8'd3, 64'hFEDC_BA98_7654_3210);
    repeat (FC + 2) cycle(0, 0, 8'd0, 64'd0);

    // Async reset while ready and mid-fill
    for (int k = 0; k < 2; k++) begin
      wait_ready();
      if (k == 1) begin
        cycle(1, 0, 8'd0, 64'd0);
        repeat (3) cycle(0, 0, 8'd0, 64'd0);
      end
      #2 rst = 1; mon_en = 0;
      #1 check("async_rst_valid", dout_valid === 1'b0, 128'(dout_valid), 128'd0);
      check("async_rst_dout", dout === '0, dout[127:0], 128'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 0; m_reset(); prev_valid = 0; mon_en = 1;
      repeat (FC + 3) cycle(0, 0, 8'd0, 64'd0);
    end

    // Randomized mix of ren pulses and seed writes (some out of range, some zero)
    repeat (600) begin
      r = ($urandom_range(0, 3) == 0);
      w = ($urandom_range(0, 24) == 0);
      l = 8'($urandom_range(0, 5));
      d = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
      cycle(r, w, l, d);
    end
    repeat (FC + 2) cycle(0, 0, 8'd0, 64'd0);
    #1 mon_en = 0;
    check("queue_empty", exp_q.size() == 0, 128'(exp_q.size()), 128'd0);

`ifdef PRNG_HEALTH_EN
    check("health_clear", health_err === 1'b0, 128'(health_err), 128'd0);
    cycle(0, 1, 8'd0, 64'd5);
    force dut.g_lane[0].step_next = 64'hDEAD_BEEF_0BAD_F00D;
    repeat (2) cycle(0, 0, 8'd0, 64'd0);
    check("health_set", health_err === 1'b1, 128'(health_err), 128'd1);
    release dut.g_lane[0].step_next;
    repeat (FC + 3) begin
      cycle(1, 0, 8'd0, 64'd0);
      check("health_block", dout_valid === 1'b0 && dout === '0, 128'(dout_valid), 128'd0);
    end
    rst = 1;
    #1 check("health_rst", health_err === 1'b0, 128'(health_err), 128'd0);
    @(negedge clk);
    rst = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
